// File: rtl/rgb2yuv_seq.sv
// Time-multiplexed RGB->YUV converter: one three-multiplier dot-product unit
// serves the Y, U and V rows in turn, with a double-buffered coefficient bank.
module rgb2yuv_seq #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DTYPE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dvi,
  output logic                   rdyo,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0] r,
  input  logic [PIXEL_WIDTH-1:0] g,
  input  logic [PIXEL_WIDTH-1:0] b,
  input  logic [15:0]            meta_datai,
  input  logic                   coef_we,
  input  logic [3:0]             coef_addr,
  input  logic [8:0]             coef_data,
  input  logic                   coef_commit,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0] y,
  output logic [PIXEL_WIDTH-1:0] u,
  output logic [PIXEL_WIDTH-1:0] v,
  output logic [15:0]            meta_datao
);

  localparam int PW     = PIXEL_WIDTH;
  localparam int PROD_W = PW + 10;
  localparam int SUM_W  = PW + 11;
  localparam int NCOEF  = 9;

  typedef logic signed [8:0] coef_t;
  typedef enum logic [1:0] {IDLE, SY, SU, SV} state_e;

  typedef struct packed {
    logic [PW-1:0]          r;
    logic [PW-1:0]          g;
    logic [PW-1:0]          b;
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [15:0]            meta;
    logic                   en;
  } pix_t;

  localparam coef_t COEF_RST [NCOEF] = '{
    9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94, -9'sd18
  };

  localparam logic signed [SUM_W-1:0] ROUND  = SUM_W'(128);
  localparam logic signed [SUM_W-1:0] ZERO   = '0;
  localparam logic signed [SUM_W-1:0] Y_MAX  = SUM_W'((1 << PW) - 1);
  localparam logic signed [SUM_W-1:0] C_MIN  = SUM_W'(-(1 << (PW - 1)));
  localparam logic signed [SUM_W-1:0] C_MAX  = SUM_W'((1 << (PW - 1)) - 1);

  state_e                 state_q, state_d;
  logic                   pending_q, pending_d;
  coef_t                  shadow_q [NCOEF];
  coef_t                  shadow_d [NCOEF];
  coef_t                  active_q [NCOEF];
  coef_t                  active_d [NCOEF];
  pix_t                   pix_q, pix_d;
  logic [PW-1:0]          y_stg_q, y_stg_d, u_stg_q, u_stg_d, v_stg_q, v_stg_d;
  logic [DTYPE_WIDTH-1:0] dtype_stg_q, dtype_stg_d;
  logic [15:0]            meta_stg_q, meta_stg_d;
  logic                   out_pend_q, out_pend_d;
  logic                   dvo_q, dvo_d;
  logic [PW-1:0]          y_q, y_d, u_q, u_d, v_q, v_d;
  logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
  logic [15:0]            meta_q, meta_d;

  logic                   accept;
  coef_t                  row_coef [3];
  logic [PW-1:0]          pix_chan [3];
  logic signed [PROD_W-1:0] prod [3];
  logic signed [SUM_W-1:0]  sum, res;
  logic [PW-1:0]          y_val, c_val;

  assign rdyo   = !pending_q && (state_q == IDLE || state_q == SV);
  assign accept = dvi && rdyo;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SY;
      SY:      state_d = SU;
      SU:      state_d = SV;
      SV:      state_d = accept ? SY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A commit arriving on the very edge that performs a copy stays pending.
  always_comb begin
    pending_d = (pending_q && state_q != IDLE) || coef_commit;
    shadow_d  = shadow_q;
    active_d  = active_q;
    for (int i = 0; i < NCOEF; i++) begin
      if (coef_we && coef_addr == 4'(i)) shadow_d[i] = coef_data;
    end
    if (pending_q && state_q == IDLE) active_d = shadow_q;
  end

  always_comb begin
    row_coef[0] = active_q[0];
    row_coef[1] = active_q[1];
    row_coef[2] = active_q[2];
    case (state_q)
      SU: begin
        row_coef[0] = active_q[3];
        row_coef[1] = active_q[4];
        row_coef[2] = active_q[5];
      end
      SV: begin
        row_coef[0] = active_q[6];
        row_coef[1] = active_q[7];
        row_coef[2] = active_q[8];
      end
      default: ;
    endcase
  end

  assign pix_chan[0] = pix_q.r;
  assign pix_chan[1] = pix_q.g;
  assign pix_chan[2] = pix_q.b;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      prod[k] = $signed({{10{1'b0}}, pix_chan[k]}) *
                $signed({{(PW + 1){row_coef[k][8]}}, row_coef[k]});
    end
    sum = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + ROUND;
    res = sum >>> 8;

    if (res < ZERO)       y_val = '0;
    else if (res > Y_MAX) y_val = '1;
    else                  y_val = res[PW-1:0];

    if (res < C_MIN)      c_val = {1'b1, {(PW - 1){1'b0}}};
    else if (res > C_MAX) c_val = {1'b0, {(PW - 1){1'b1}}};
    else                  c_val = res[PW-1:0];
  end

  // Staging decouples the finished pixel from a new one captured in SV.
  always_comb begin
    pix_d       = pix_q;
    y_stg_d     = y_stg_q;
    u_stg_d     = u_stg_q;
    v_stg_d     = v_stg_q;
    dtype_stg_d = dtype_stg_q;
    meta_stg_d  = meta_stg_q;
    out_pend_d  = (state_q == SV);
    dvo_d       = out_pend_q;
    y_d         = y_q;
    u_d         = u_q;
    v_d         = v_q;
    dtypeo_d    = dtypeo_q;
    meta_d      = meta_q;

    if (accept) pix_d = '{r: r, g: g, b: b, dtype: dtypei, meta: meta_datai, en: enable};

    case (state_q)
      SY: y_stg_d = pix_q.en ? y_val : pix_q.r;
      SU: u_stg_d = pix_q.en ? c_val : pix_q.g;
      SV: begin
        v_stg_d     = pix_q.en ? c_val : pix_q.b;
        dtype_stg_d = pix_q.dtype;
        meta_stg_d  = pix_q.meta;
      end
      default: ;
    endcase

    if (out_pend_q) begin
      y_d      = y_stg_q;
      u_d      = u_stg_q;
      v_d      = v_stg_q;
      dtypeo_d = dtype_stg_q;
      meta_d   = meta_stg_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      // NOTE: the coefficient banks are small register files that must power
      // up holding the default matrix, so they are reset like ordinary flops.
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= COEF_RST[i];
        active_q[i] <= COEF_RST[i];
      end
      pix_q       <= '0;
      y_stg_q     <= '0;
      u_stg_q     <= '0;
      v_stg_q     <= '0;
      dtype_stg_q <= '0;
      meta_stg_q  <= '0;
      out_pend_q  <= 1'b0;
      dvo_q       <= 1'b0;
      y_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      dtypeo_q    <= '0;
      meta_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pix_q       <= pix_d;
      y_stg_q     <= y_stg_d;
      u_stg_q     <= u_stg_d;
      v_stg_q     <= v_stg_d;
      dtype_stg_q <= dtype_stg_d;
      meta_stg_q  <= meta_stg_d;
      out_pend_q  <= out_pend_d;
      dvo_q       <= dvo_d;
      y_q         <= y_d;
      u_q         <= u_d;
      v_q         <= v_d;
      dtypeo_q    <= dtypeo_d;
      meta_q      <= meta_d;
    end
  end

  assign dvo        = dvo_q;
  assign y          = y_q;
  assign u          = u_q;
  assign v          = v_q;
  assign dtypeo     = dtypeo_q;
  assign meta_datao = meta_q;

endmodule

// File: tb/tb_rgb2yuv_seq.sv
// Directed self-checking bench for rgb2yuv_seq: default and programmed
// coefficients, clamping, streaming throughput, deferred commit, reset, bypass.
module tb_rgb2yuv_seq;

  localparam int PW = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset, enable, dvi, rdyo;
  logic [DW-1:0] dtypei, dtypeo;
  logic [PW-1:0] r, g, b, y, u, v;
  logic [15:0]   meta_datai, meta_datao;
  logic          coef_we, coef_commit, dvo;
  logic [3:0]    coef_addr;
  logic [8:0]    coef_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb2yuv_seq #(.PIXEL_WIDTH(PW), .DTYPE_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dvi(dvi), .rdyo(rdyo),
    .dtypei(dtypei), .r(r), .g(g), .b(b), .meta_datai(meta_datai),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .dvo(dvo), .dtypeo(dtypeo),
    .y(y), .u(u), .v(v), .meta_datao(meta_datao)
  );

  // Stream vectors, default matrix, hand-computed.
  logic [PW-1:0] s_r  [6] = '{8'd255, 8'd0,   8'd0,   8'd128, 8'd16, 8'd0};
  logic [PW-1:0] s_g  [6] = '{8'd0,   8'd255, 8'd0,   8'd128, 8'd16, 8'd0};
  logic [PW-1:0] s_b  [6] = '{8'd0,   8'd0,   8'd255, 8'd128, 8'd16, 8'd0};
  logic [PW-1:0] s_ey [6] = '{8'd66,  8'd128, 8'd25,  8'd110, 8'd14, 8'd0};
  logic [PW-1:0] s_eu [6] = '{8'hDA,  8'hB6,  8'h70,  8'h00,  8'h00, 8'h00};
  logic [PW-1:0] s_ev [6] = '{8'h70,  8'hA2,  8'hEE,  8'h00,  8'h00, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [8:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_pix(input int i);
    r          = s_r[i];
    g          = s_g[i];
    b          = s_b[i];
    dtypei     = DW'(i + 1);
    meta_datai = 16'hA000 + 16'(i);
  endtask

  // Waits for rdyo, sends one pixel and checks latency and the result.
  task automatic run_pixel(input string tag, input logic [7:0] rr, gg, bb,
                           input logic en, input logic [DW-1:0] dt, input logic [15:0] md,
                           input logic [7:0] ey, eu, ev);
    int n;
    n = 0;
    while (!rdyo && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(rdyo), 1);
    r = rr; g = gg; b = bb; enable = en; dtypei = dt; meta_datai = md;
    dvi = 1'b1;
    tick();
    dvi = 1'b0;
    n = 0;
    while (!dvo && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 4);
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_u"}, 32'(u), 32'(eu));
    check({tag, "_v"}, 32'(v), 32'(ev));
    check({tag, "_dtype"}, 32'(dtypeo), 32'(dt));
    check({tag, "_meta"}, 32'(meta_datao), 32'(md));
    tick();
    check({tag, "_pulse"}, 32'(dvo), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, outn, last_acc, last_out, pulses;
    logic was_rdy;

    reset = 1'b1; enable = 1'b1; dvi = 1'b0; dtypei = '0; r = '0; g = '0; b = '0;
    meta_datai = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_dvo", 32'(dvo), 0);
    check("rst_y", 32'(y), 0);
    check("rst_u", 32'(u), 0);
    check("rst_v", 32'(v), 0);
    check("rst_dtype", 32'(dtypeo), 0);
    check("rst_meta", 32'(meta_datao), 0);
    check("rst_rdyo", 32'(rdyo), 1);

    run_pixel("white", 8'd255, 8'd255, 8'd255, 1'b1, 4'd3, 16'h1234, 8'd219, 8'h00, 8'h00);
    run_pixel("red", 8'd255, 8'd0, 8'd0, 1'b1, 4'd5, 16'hBEEF, 8'd66, 8'hDA, 8'h70);

    // Y row all 255, U row all -256; last write coincides with the commit.
    write_coef(4'd0, 9'd255);
    write_coef(4'd1, 9'd255);
    write_coef(4'd2, 9'd255);
    write_coef(4'd3, 9'h100);
    write_coef(4'd4, 9'h100);
    coef_commit = 1'b1;
    write_coef(4'd5, 9'h100);
    coef_commit = 1'b0;
    check("commit_holdoff", 32'(rdyo), 0);
    run_pixel("clamp", 8'd255, 8'd255, 8'd255, 1'b1, 4'd7, 16'h0F0F, 8'hFF, 8'h80, 8'h00);

    do_reset();

    // Streaming with dvi held high.
    acc = 0; outn = 0; last_acc = 0; last_out = 0;
    enable = 1'b1;
    set_pix(0);
    dvi = 1'b1;
    for (int cyc = 0; cyc < 60 && outn < 6; cyc++) begin
      was_rdy = rdyo && dvi;
      tick();
      if (was_rdy) begin
        if (acc > 0) check("strm_acc_gap", 32'(cyc - last_acc), 3);
        last_acc = cyc;
        acc++;
        if (acc < 6) set_pix(acc);
        else dvi = 1'b0;
      end
      if (dvo) begin
        check("strm_y", 32'(y), 32'(s_ey[outn]));
        check("strm_u", 32'(u), 32'(s_eu[outn]));
        check("strm_v", 32'(v), 32'(s_ev[outn]));
        check("strm_dtype", 32'(dtypeo), 32'(outn + 1));
        check("strm_meta", 32'(meta_datao), 32'(16'hA000 + 16'(outn)));
        if (outn > 0) check("strm_out_gap", 32'(cyc - last_out), 3);
        last_out = cyc;
        outn++;
      end
    end
    dvi = 1'b0;
    check("strm_accepts", 32'(acc), 6);
    check("strm_outputs", 32'(outn), 6);
    tick();
    tick();

    // New Y row (r/2) staged in the shadow bank; commit one cycle after accept.
    write_coef(4'd0, 9'd128);
    write_coef(4'd1, 9'd0);
    write_coef(4'd2, 9'd0);
    r = 8'd255; g = 8'd0; b = 8'd0; dtypei = 4'd9; meta_datai = 16'h5555;
    check("late_rdy", 32'(rdyo), 1);
    dvi = 1'b1;
    tick();
    dvi = 1'b0;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    check("late_rdyo_su", 32'(rdyo), 0);
    tick();
    check("late_rdyo_sv", 32'(rdyo), 0);
    tick();
    check("late_rdyo_idle", 32'(rdyo), 0);
    tick();
    check("late_dvo", 32'(dvo), 1);
    check("late_old_y", 32'(y), 66);
    check("late_old_u", 32'(u), 32'h00DA);
    check("late_old_v", 32'(v), 32'h0070);
    check("late_rdyo_up", 32'(rdyo), 1);
    run_pixel("late_new", 8'd255, 8'd0, 8'd0, 1'b1, 4'd10, 16'h6666, 8'd128, 8'hDA, 8'h70);

    // Reset while the pixel is in SU; a commit during reset is dropped.
    r = 8'd255; g = 8'd255; b = 8'd255; dtypei = 4'd2; meta_datai = 16'h7777;
    dvi = 1'b1;
    tick();
    dvi = 1'b0;
    tick();
    reset = 1'b1;
    coef_commit = 1'b1;
    #1;
    check("abort_dvo", 32'(dvo), 0);
    check("abort_y", 32'(y), 0);
    check("abort_u", 32'(u), 0);
    check("abort_v", 32'(v), 0);
    check("abort_dtype", 32'(dtypeo), 0);
    check("abort_meta", 32'(meta_datao), 0);
    tick();
    coef_commit = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_rdyo", 32'(rdyo), 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dvo) pulses++;
    end
    check("abort_no_dvo", 32'(pulses), 0);

    run_pixel("bypass", 8'd10, 8'd20, 8'd30, 1'b0, 4'd4, 16'hC0DE, 8'd10, 8'd20, 8'd30);
    run_pixel("dflt_after_rst", 8'd255, 8'd0, 8'd0, 1'b1, 4'd1, 16'h0001, 8'd66, 8'hDA, 8'h70);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
